// File: rtl/w4823_fir_cload.sv
// Coefficient load sequencer: streams host words into the FIR coefficient memory as
// registered (cin, caddr, cload) writes. Optional burst checksum under W4823_CLOAD_CSUM_EN.
module w4823_fir_cload #(
   parameter int unsigned NCOEF = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  base,
   input  logic [6:0]  count,
   input  logic [16:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        stall,
   output logic [16:0] cin,
   output logic [5:0]  caddr,
   output logic        cload,
   output logic        busy,
   output logic        done,
   output logic        wrap
`ifdef W4823_CLOAD_CSUM_EN
   ,
   output logic [16:0] csum
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [5:0] LAST_ADDR = 6'(NCOEF - 1);
   localparam logic [6:0] MAX_COUNT = 7'(NCOEF);

   logic [1:0]  state_q, state_d;
   logic [5:0]  ptr_q, ptr_d;
   logic [6:0]  rem_q, rem_d;
   logic [16:0] cin_q, cin_d;
   logic [5:0]  caddr_q, caddr_d;
   logic        cload_q, cload_d;
   logic        wrap_q, wrap_d;
   logic        beat;
   logic        start_acc;

   assign s_ready   = (state_q == LOAD) & ~stall;
   assign beat      = s_valid & s_ready;
   assign start_acc = (state_q == IDLE) & start;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      cin_d   = cin_q;
      caddr_d = caddr_q;
      cload_d = 1'b0;
      wrap_d  = wrap_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d   = base;
               rem_d   = (count > MAX_COUNT) ? MAX_COUNT : count;
               wrap_d  = 1'b0;
               state_d = (count == 7'd0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (beat) begin
               cin_d   = s_data;
               caddr_d = ptr_q;
               cload_d = 1'b1;
               ptr_d   = (ptr_q == LAST_ADDR) ? 6'd0 : 6'(ptr_q + 6'd1);
               rem_d   = 7'(rem_q - 7'd1);
               // Only a wrap that is actually followed by a write at address 0 counts.
               if ((ptr_q == LAST_ADDR) && (rem_q != 7'd1)) begin
                  wrap_d = 1'b1;
               end
               if (rem_q == 7'd1) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 6'd0;
         rem_q   <= 7'd0;
         cin_q   <= 17'd0;
         caddr_q <= 6'd0;
         cload_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         cin_q   <= cin_d;
         caddr_q <= caddr_d;
         cload_q <= cload_d;
         wrap_q  <= wrap_d;
      end
   end

   assign cin   = cin_q;
   assign caddr = caddr_q;
   assign cload = cload_q;
   assign wrap  = wrap_q;
   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);

`ifdef W4823_CLOAD_CSUM_EN
   logic [16:0] csum_q, csum_d;

   // Accumulated at acceptance, so the final beat is included by the time done is high.
   always_comb begin
      csum_d = csum_q;
      if (start_acc) begin
         csum_d = 17'd0;
      end else if ((state_q == LOAD) && beat) begin
         csum_d = 17'(csum_q + s_data);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= 17'd0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign csum = csum_q;
`else
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_w4823_fir_cload.sv
// Directed bench for w4823_fir_cload: vector table plus full-burst, clamp and
// mid-burst reset sequences.
module tb_w4823_fir_cload;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  base;
   logic [6:0]  count;
   logic [16:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        stall;
   logic [16:0] cin;
   logic [5:0]  caddr;
   logic        cload;
   logic        busy;
   logic        done;
   logic        wrap;
`ifdef W4823_CLOAD_CSUM_EN
   logic [16:0] csum;
`endif

   int n_vec = 0;
   int n_err = 0;

   w4823_fir_cload #(.NCOEF(64)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .base    (base),
      .count   (count),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .stall   (stall),
      .cin     (cin),
      .caddr   (caddr),
      .cload   (cload),
      .busy    (busy),
      .done    (done),
      .wrap    (wrap)
`ifdef W4823_CLOAD_CSUM_EN
      ,
      .csum    (csum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        start;
      logic [5:0]  base;
      logic [6:0]  count;
      logic [16:0] data;
      logic        valid;
      logic        stall;
      logic        e_rdy;
      logic [16:0] e_cin;
      logic [5:0]  e_caddr;
      logic        e_cload;
      logic        e_busy;
      logic        e_done;
      logic        e_wrap;
      logic [16:0] e_csum;
   } vec_t;

   vec_t vt[23];

   function automatic vec_t mk(input logic r, input logic st, input int b, input int c,
                               input int d, input logic v, input logic sl, input logic rdy,
                               input int ecin, input int ecaddr, input logic ecl,
                               input logic ebusy, input logic edone, input logic ewrap,
                               input int ecsum);
      vec_t x;
      x.rst = r;       x.start = st;      x.base = 6'(b);      x.count = 7'(c);
      x.data = 17'(d); x.valid = v;       x.stall = sl;        x.e_rdy = rdy;
      x.e_cin = 17'(ecin); x.e_caddr = 6'(ecaddr); x.e_cload = ecl; x.e_busy = ebusy;
      x.e_done = edone;    x.e_wrap = ewrap;       x.e_csum = 17'(ecsum);
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic st, input logic [5:0] b,
                        input logic [6:0] c, input logic [16:0] d, input logic v,
                        input logic sl);
      @(negedge clk);
      rst = r; start = st; base = b; count = c; s_data = d; s_valid = v; stall = sl;
      @(posedge clk);
      #1;
   endtask

   // 64 beats from base 0; cnt of 64 or above must both give exactly 64 writes.
   task automatic full_burst(input logic [6:0] cnt, input string tag);
      int ncl;
      logic [16:0] sum;
      ncl = 0;
      sum = 17'd0;
      drive(1'b0, 1'b1, 6'd0, cnt, 17'd0, 1'b0, 1'b0);
      chk({tag, " busy after start"}, 32'(busy), 32'd1);
      for (int k = 0; k < 64; k++) begin
         drive(1'b0, 1'b0, 6'd0, 7'd0, 17'(3 * k + 1), 1'b1, 1'b0);
         if (cload) ncl++;
         sum = 17'(sum + 17'(3 * k + 1));
         chk($sformatf("%s caddr beat %0d", tag, k), 32'(caddr), 32'(k));
         chk($sformatf("%s cin beat %0d", tag, k), 32'(cin), 32'(3 * k + 1));
      end
      chk({tag, " done after last beat"}, 32'(done), 32'd1);
      chk({tag, " wrap"}, 32'(wrap), 32'd0);
`ifdef W4823_CLOAD_CSUM_EN
      chk({tag, " csum"}, 32'(csum), 32'(sum));
`endif
      drive(1'b0, 1'b0, 6'd0, 7'd0, 17'd0, 1'b1, 1'b0);
      chk({tag, " busy after done"}, 32'(busy), 32'd0);
      chk({tag, " done single"}, 32'(done), 32'd0);
      chk({tag, " cload after done"}, 32'(cload), 32'd0);
      chk({tag, " cload count"}, 32'(ncl), 32'd64);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base = 6'd0; count = 7'd0;
      s_data = 17'd0; s_valid = 1'b0; stall = 1'b0;

      //             rst st  b   c  d  v  sl | rdy cin ca cl by dn wr csum
      vt[0]  = mk(1, 0,  0, 0,  0, 0, 0,  0,  0,  0, 0, 0, 0, 0,  0);
      vt[1]  = mk(0, 1, 62, 4,  0, 0, 0,  1,  0,  0, 0, 1, 0, 0,  0);
      vt[2]  = mk(0, 0,  0, 0,  1, 1, 0,  1,  1, 62, 1, 1, 0, 0,  1);
      vt[3]  = mk(0, 0,  0, 0,  2, 1, 0,  1,  2, 63, 1, 1, 0, 1,  3);
      vt[4]  = mk(0, 0,  0, 0,  3, 1, 0,  1,  3,  0, 1, 1, 0, 1,  6);
      vt[5]  = mk(0, 0,  0, 0,  4, 1, 0,  0,  4,  1, 1, 1, 1, 1, 10);
      vt[6]  = mk(0, 0,  0, 0,  0, 0, 0,  0,  4,  1, 0, 0, 0, 1, 10);
      vt[7]  = mk(0, 1, 10, 0,  0, 0, 0,  0,  4,  1, 0, 1, 1, 0,  0);
      vt[8]  = mk(0, 0,  0, 0,  0, 0, 0,  0,  4,  1, 0, 0, 0, 0,  0);
      vt[9]  = mk(0, 1,  3, 3,  7, 1, 0,  1,  4,  1, 0, 1, 0, 0,  0);
      vt[10] = mk(0, 0,  0, 0,  7, 1, 0,  1,  7,  3, 1, 1, 0, 0,  7);
      for (int i = 11; i < 16; i++) begin
         vt[i] = mk(0, 0, 0, 0, 8, 1, 1,  0,  7,  3, 0, 1, 0, 0,  7);
      end
      vt[16] = mk(0, 0,  0, 0,  8, 1, 0,  1,  8,  4, 1, 1, 0, 0, 15);
      vt[17] = mk(0, 0,  0, 0,  9, 1, 0,  0,  9,  5, 1, 1, 1, 0, 24);
      vt[18] = mk(0, 0,  0, 0,  0, 0, 0,  0,  9,  5, 0, 0, 0, 0, 24);
      vt[19] = mk(0, 1, 20, 2,  0, 0, 0,  1,  9,  5, 0, 1, 0, 0,  0);
      vt[20] = mk(0, 1, 40, 5, 11, 1, 0,  1, 11, 20, 1, 1, 0, 0, 11);
      vt[21] = mk(0, 1, 40, 5, 12, 1, 0,  0, 12, 21, 1, 1, 1, 0, 23);
      vt[22] = mk(0, 0,  0, 0,  0, 0, 0,  0, 12, 21, 0, 0, 0, 0, 23);

      for (int i = 0; i < 23; i++) begin
         drive(vt[i].rst, vt[i].start, vt[i].base, vt[i].count, vt[i].data, vt[i].valid,
               vt[i].stall);
         chk($sformatf("v%0d s_ready", i), 32'(s_ready), 32'(vt[i].e_rdy));
         chk($sformatf("v%0d cin", i), 32'(cin), 32'(vt[i].e_cin));
         chk($sformatf("v%0d caddr", i), 32'(caddr), 32'(vt[i].e_caddr));
         chk($sformatf("v%0d cload", i), 32'(cload), 32'(vt[i].e_cload));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
         chk($sformatf("v%0d done", i), 32'(done), 32'(vt[i].e_done));
         chk($sformatf("v%0d wrap", i), 32'(wrap), 32'(vt[i].e_wrap));
`ifdef W4823_CLOAD_CSUM_EN
         chk($sformatf("v%0d csum", i), 32'(csum), 32'(vt[i].e_csum));
`endif
      end

      full_burst(7'd64, "fb64");
      full_burst(7'd100, "fb100");

      // Reset after 10 of 20 beats, then a single-beat burst at address 5.
      drive(1'b0, 1'b1, 6'd0, 7'd20, 17'd0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, 6'd0, 7'd0, 17'(100 + k), 1'b1, 1'b0);
      end
      chk("mid caddr before rst", 32'(caddr), 32'd9);
      drive(1'b1, 1'b0, 6'd0, 7'd0, 17'd110, 1'b1, 1'b0);
      chk("rst cin", 32'(cin), 32'd0);
      chk("rst caddr", 32'(caddr), 32'd0);
      chk("rst cload", 32'(cload), 32'd0);
      chk("rst s_ready", 32'(s_ready), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst wrap", 32'(wrap), 32'd0);
      drive(1'b0, 1'b0, 6'd0, 7'd0, 17'd111, 1'b1, 1'b0);
      chk("post rst done", 32'(done), 32'd0);
      chk("post rst cload", 32'(cload), 32'd0);
      drive(1'b0, 1'b1, 6'd5, 7'd1, 17'd0, 1'b0, 1'b0);
      chk("single busy", 32'(busy), 32'd1);
      drive(1'b0, 1'b0, 6'd0, 7'd0, 17'd99, 1'b1, 1'b0);
      chk("single cload", 32'(cload), 32'd1);
      chk("single caddr", 32'(caddr), 32'd5);
      chk("single cin", 32'(cin), 32'd99);
      chk("single done", 32'(done), 32'd1);
      drive(1'b0, 1'b0, 6'd0, 7'd0, 17'd98, 1'b1, 1'b0);
      chk("single cload end", 32'(cload), 32'd0);
      chk("single busy end", 32'(busy), 32'd0);
      chk("single caddr hold", 32'(caddr), 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
